// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared definitions for the 8-requester round-robin scheduler: sizes,
// output-register state encoding and a reference round-robin pick function.
package mux8_rr_scheduler_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Walk ptr+7 down to ptr so the last hit written is the first in round-robin order.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   ptr);
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p.found = 1'b0;
    p.idx   = {SEL_W{1'b0}};
    idx     = {SEL_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux8_rr_scheduler_rr_pick8.sv
// Combinational round-robin winner search: rotate req so ptr sits at bit 0,
// take the lowest set bit, then add ptr back to recover the requester index.
module rr_pick8
  import mux8_rr_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   win,
  output logic               found
);

  logic [NUM_REQ-1:0] rot_s;
  logic [SEL_W-1:0]   off_s;

  // Rotate right by ptr and priority-encode the lowest set bit.
  always_comb begin
    rot_s = NUM_REQ'({req, req} >> ptr);
    off_s = {SEL_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = SEL_W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  assign win   = off_s + ptr;
  assign found = |req;

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 word select among 8 requesters,
// with a single registered output stage on a valid/ready handshake.
module mux8_rr_scheduler
  import mux8_rr_scheduler_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] in_data,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [SEL_W-1:0]      out_src
);

  state_t           state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] win_s;
  logic             found_s;
  logic             cap_s;
  logic [DW-1:0]    word_s;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .win   (win_s),
    .found (found_s)
  );

  // 8:1 word select driven by the winner index.
  always_comb begin
    case (win_s)
      3'd0:    word_s = in_data[0*DW +: DW];
      3'd1:    word_s = in_data[1*DW +: DW];
      3'd2:    word_s = in_data[2*DW +: DW];
      3'd3:    word_s = in_data[3*DW +: DW];
      3'd4:    word_s = in_data[4*DW +: DW];
      3'd5:    word_s = in_data[5*DW +: DW];
      3'd6:    word_s = in_data[6*DW +: DW];
      3'd7:    word_s = in_data[7*DW +: DW];
      default: word_s = {DW{1'b0}};
    endcase
  end

  // A capture needs a request and a free slot, or one being freed this cycle.
  always_comb begin
    cap_s = 1'b0;
    case (state_r)
      EMPTY:   cap_s = found_s;
      FULL:    cap_s = found_s && out_ready;
      default: cap_s = 1'b0;
    endcase
  end

  // Output register, pointer and state; a drain and refill in one edge keeps FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= EMPTY;
      ptr_r     <= {SEL_W{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {DW{1'b0}};
      out_src   <= {SEL_W{1'b0}};
      sel       <= {SEL_W{1'b0}};
      req_ack   <= {NUM_REQ{1'b0}};
    end else begin
      req_ack <= {NUM_REQ{1'b0}};
      if (cap_s) begin
        state_r   <= FULL;
        out_valid <= 1'b1;
        out_data  <= word_s;
        out_src   <= win_s;
        sel       <= win_s;
        req_ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
        ptr_r     <= win_s + 3'd1;
      end else if (state_r == FULL && out_ready) begin
        state_r   <= EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed bench for mux8_rr_scheduler with a scoreboard of expected captures.
module tb_mux8_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [63:0] in_data;
  logic [7:0]  req_ack;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_src;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] src;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mux8_rr_scheduler #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_data   (in_data),
    .req_ack   (req_ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_slice(input int i, input logic [7:0] v);
    in_data[i*8 +: 8] = v;
  endtask

  // Advance one edge, sample #1 later, and score any capture against the queue.
  task automatic tick();
    exp_t e;
    logic [7:0] onehot;
    @(posedge clk);
    #1;
    chk("sel_eq_src", {29'd0, sel}, {29'd0, out_src});
    if (req_ack !== 8'h00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {24'd0, req_ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        onehot = 8'h01 << e.src;
        chk("cap_src",   {29'd0, out_src},  {29'd0, e.src});
        chk("cap_data",  {24'd0, out_data}, {24'd0, e.data});
        chk("cap_ack",   {24'd0, req_ack},  {24'd0, onehot});
        chk("cap_valid", {31'd0, out_valid}, 32'd1);
      end
    end
  endtask

  task automatic cap_tick(input logic [2:0] src, input logic [7:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    exp_q.push_back(e);
    tick();
    chk("pending_caps", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;
    in_data   = 64'd0;
    for (int i = 0; i < 8; i++) set_slice(i, 8'(i * 17));

    // Reset with every requester active
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ack",   {24'd0, req_ack},   32'd0);
    chk("rst_sel",   {29'd0, sel},       32'd0);
    chk("rst_data",  {24'd0, out_data},  32'd0);
    rst = 1'b0;

    // Rotation: 0..7 then 0 again, valid never drops
    for (int i = 0; i < 9; i++) cap_tick(3'(i % 8), 8'((i % 8) * 17));

    // Single requester granted every cycle
    req = 8'b0010_0000;
    set_slice(5, 8'hA5);
    for (int i = 0; i < 3; i++) cap_tick(3'd5, 8'hA5);

    // Stall: capture from 2, then hold with out_ready low
    req = 8'b0000_0100;
    set_slice(2, 8'h22);
    set_slice(3, 8'h33);
    cap_tick(3'd2, 8'h22);
    req       = 8'h0C;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data",  {24'd0, out_data},  32'h22);
      chk("stall_src",   {29'd0, out_src},   32'd2);
      chk("stall_ack",   {24'd0, req_ack},   32'd0);
    end
    out_ready = 1'b1;
    req       = 8'b0000_1000;
    cap_tick(3'd3, 8'h33);

    // Wrap and skip: grant 6 leaves ptr at 7, then 0, 1, then idle
    req = 8'b0100_0000;
    set_slice(6, 8'h66);
    cap_tick(3'd6, 8'h66);
    req = 8'b0000_0011;
    set_slice(0, 8'hC0);
    set_slice(1, 8'hC1);
    cap_tick(3'd0, 8'hC0);
    req = 8'b0000_0010;
    cap_tick(3'd1, 8'hC1);
    req = 8'h00;
    tick();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_ack",   {24'd0, req_ack},   32'd0);
    chk("idle_data",  {24'd0, out_data},  32'hC1);
    chk("idle_src",   {29'd0, out_src},   32'd1);
    tick();
    chk("ready_noeffect", {31'd0, out_valid}, 32'd0);

    // Reset while FULL and stalled
    req = 8'b1000_0000;
    set_slice(7, 8'h77);
    cap_tick(3'd7, 8'h77);
    out_ready = 1'b0;
    req       = 8'b1000_0001;
    tick();
    chk("full_stall_ack", {24'd0, req_ack}, 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ack",   {24'd0, req_ack},   32'd0);
    chk("mid_rst_sel",   {29'd0, sel},       32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    cap_tick(3'd0, 8'hC0);
    req = 8'h00;
    tick();
    chk("final_valid", {31'd0, out_valid}, 32'd0);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8:1 selection datapath among 8 requesters.
- Arbitrates among the requests, drives the 3-bit select, captures the selected word into an output register and presents it downstream over a valid/ready handshake.
- Sits between 8 independent producers and a single consumer port. Sustains one transfer per cycle when the consumer is always ready.

Parameters:
- DW, 8, data width of each requester word and of the output word.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  8  per-requester request; req[i] high means in_data slice i is valid.
- in_data  input  8*DW  packed requester words; slice i is in_data[i*DW +: DW].
- req_ack  output  8  one-hot, one-cycle pulse; the requester's word was captured this cycle.
- sel  output  3  index of the most recent capture; it is the mux select value.
- out_valid  output  1  out_data holds a word not yet accepted downstream.
- out_ready  input  1  downstream accepts out_data when high together with out_valid.
- out_data  output  DW  captured word.
- out_src  output  3  requester index that out_data came from.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_src=0, sel=0, req_ack=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority first.
  - State=EMPTY.
- States:
  - EMPTY: output register holds nothing.
  - FULL: output register holds a word awaiting out_ready.
- Capture condition: cap = (req != 0) && (state==EMPTY || (out_valid && out_ready)).
- Winner w: the first i with req[i]=1, searching ptr, ptr+1, ..., ptr+7 modulo 8.
- On cap, on the clock edge:
  - out_data <= in_data slice w.
  - out_src <= w; sel <= w.
  - out_valid <= 1; state <= FULL.
  - req_ack <= one-hot(w) for exactly that cycle after the edge.
  - ptr <= (w+1) mod 8; 7 wraps to 0.
- Capture latency: req sampled in cycle t gives out_valid and req_ack in cycle t+1. The requester must hold req and data stable until it sees req_ack. It must deassert req or present new data in the cycle req_ack is high.
- Transfer without refill: out_valid && out_ready && req==0 gives out_valid <= 0 and state <= EMPTY. out_data and out_src keep their values.
- Back-to-back: a transfer and a new capture in the same cycle leaves state FULL with no bubble. Full throughput is one word per cycle.
- Stall: out_valid high and out_ready low means out_data, out_src, sel and ptr are held. No capture and no req_ack occur. Requests wait.
- req_ack is 0 in every cycle without a capture. At most one bit is ever set.
- sel changes only on capture, and always equals out_src.
- A single active requester is granted every cycle it is eligible. The pointer does not block it.
- Fairness: with all 8 requesting continuously and out_ready=1, the grant order is 0,1,2,...,7,0,... Each requester waits at most 7 grants.
- Reset mid-operation: rst overrides everything in the same edge. A pending out_data is discarded, with no req_ack and no valid. Priority returns to requester 0.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package holds:
  - constant NUM_REQ=8 and SEL_W=3.
  - state enum {EMPTY, FULL}.
  - function rr_pick(req, ptr) returning the winner index and a found flag.
- One natural sub-module, rr_pick8: combinational rotate, priority-encode, un-rotate from req and ptr to w and found.
- The data select reuses the team's existing 8:1 selection block, one instance per data bit, or a DW-wide variant.

Test Plan:
- Reset: assert rst with req=8'hFF for 2 cycles -> out_valid=0, req_ack=0, sel=0. After release, the first grant goes to 0.
- Single requester: req=8'b0010_0000, slice5=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_src=5, req_ack=8'b0010_0000. Repeats every cycle while held.
- Rotation: req=8'hFF held, out_ready=1, slice i = i -> out_src sequence 0,1,...,7,0, with out_valid continuously high.
- Stall: capture from requester 2, then out_ready=0 for 4 cycles with req=8'h0C -> out_data, sel and out_src stable, req_ack=0. Releasing out_ready gives a capture from requester 3 next.
- Wrap and skip: ptr=7 after a grant to 6, req=8'b0000_0011 -> grant 0, then 1, then idle with out_valid=0 after the final transfer.
- Reset while FULL and stalled: rst for 1 cycle -> out_valid=0 next cycle. With req=8'b1000_0001, the first grant is to 0, not 7.
